// File: rtl/joystick_serial_pkg.sv
// joy_pkg: shared types and constants for the DB9 joystick serial poller.
//   joy_state_t      - scan FSM states
//   JOY_BITS         - width of one joystick word
//   FRAME_BITS       - bits shifted per scan frame (two joysticks)
//   JOY_*            - bit positions inside a joystick word (active low)
//   frame_joy1/2     - split a scan frame into the two joystick words
package joy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } joy_state_t;

  localparam int JOY_BITS   = 8;
  localparam int FRAME_BITS = 16;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_FIRE1 = 4;
  localparam int JOY_FIRE2 = 5;

  // The first joystick in the chain is shifted out first, so it ends up in
  // the upper half of the frame.
  function automatic logic [JOY_BITS-1:0] frame_joy1(input logic [FRAME_BITS-1:0] f);
    return f[FRAME_BITS-1 -: JOY_BITS];
  endfunction

  function automatic logic [JOY_BITS-1:0] frame_joy2(input logic [FRAME_BITS-1:0] f);
    return f[JOY_BITS-1:0];
  endfunction

endpackage

// File: rtl/joystick_serial_if.sv
// joystick_serial_if: signals between the poller, the external 74HC165
// chain and the downstream consumers of the joystick words.
//   joyD      - serial data from the chain (into the poller)
//   joyCk     - shift clock to the chain, rising edge shifts
//   joyLd     - parallel load to the chain, active low
//   joy1_o    - joystick 1 word, active low, 8'hFF = idle
//   joy2_o    - joystick 2 word, active low
//   joy_valid - one-cycle pulse when a validated frame updates the words
// modport master: the poller; modport slave: chain model / consumers.
interface joystick_serial_if;
  import joy_pkg::*;

  logic                joyD;
  logic                joyCk;
  logic                joyLd;
  logic [JOY_BITS-1:0] joy1_o;
  logic [JOY_BITS-1:0] joy2_o;
  logic                joy_valid;

  modport master (
    input  joyD,
    output joyCk,
    output joyLd,
    output joy1_o,
    output joy2_o,
    output joy_valid
  );

  modport slave (
    output joyD,
    input  joyCk,
    input  joyLd,
    input  joy1_o,
    input  joy2_o,
    input  joy_valid
  );

endinterface

// File: rtl/joystick_serial_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, both flops reset to 1
//   d     - asynchronous input
//   q     - synchronized output
// Resetting to 1 matches an idle (pulled-up) serial line, so it can be
// reused for the tape input as well.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/joystick_serial.sv
// joystick_serial: polls two 8-bit DB9 joysticks through an external
// 74HC165-style parallel-in/serial-out chain and publishes the words only
// when two consecutive scan frames agree.
//   clk_i   - system clock
//   res_n_i - asynchronous active-low reset (release expected synchronous
//             to clk_i)
//   bus     - joystick_serial_if.master: joyD in; joyCk, joyLd, joy1_o,
//             joy2_o, joy_valid out
// Parameters:
//   CLK_DIV   - clk_i cycles per joyCk half-period (>= 4)
//   GAP_TICKS - idle ticks between frames (>= 1)
// Frame period is CLK_DIV*(GAP_TICKS+32)+1 clk_i cycles.
module joystick_serial
  import joy_pkg::*;
#(
  parameter int CLK_DIV   = 12,
  parameter int GAP_TICKS = 16
) (
  input  logic clk_i,
  input  logic res_n_i,
  joystick_serial_if.master bus
);

  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam int BIT_W = $clog2(FRAME_BITS);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  joy_state_t state, state_nxt;

  logic [PRE_W-1:0]      presc;
  logic                  tick;
  logic [GAP_W-1:0]      gap_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] frame;
  logic [FRAME_BITS-1:0] prev;
  logic                  joyd_s;
  logic                  frame_match;

  sync_2ff u_sync (
    .clk   (clk_i),
    .rst_n (res_n_i),
    .d     (bus.joyD),
    .q     (joyd_s)
  );

  assign tick        = (presc == PRE_LAST);
  assign frame_match = (frame == prev);

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // The last-bit check in SHIFT_LO takes priority over going high again,
  // and DONE always lasts exactly one clk_i cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (tick && (gap_cnt == GAP_LAST)) state_nxt = LOAD;
      LOAD:     if (tick) state_nxt = SHIFT_LO;
      SHIFT_LO: if (tick) state_nxt = (bit_cnt == BIT_LAST) ? DONE : SHIFT_HI;
      SHIFT_HI: if (tick) state_nxt = SHIFT_LO;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Clearing the prescaler in DONE makes every IDLE phase start from a
  // fresh count, which gives the extra single cycle in the frame period.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i)                  presc <= '0;
    else if (state == DONE || tick) presc <= '0;
    else                           presc <= presc + 1'b1;
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i)           gap_cnt <= '0;
    else if (state != IDLE) gap_cnt <= '0;
    else if (tick)          gap_cnt <= gap_cnt + 1'b1;
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i)                        bit_cnt <= '0;
    else if (state == LOAD)              bit_cnt <= '0;
    else if (state == SHIFT_HI && tick)  bit_cnt <= bit_cnt + 1'b1;
  end

  // Sampling at the end of the low phase means the chain output has been
  // stable for a full half-period (plus synchronizer delay) before use.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i)                        frame <= '1;
    else if (state == SHIFT_LO && tick)  frame <= {frame[FRAME_BITS-2:0], joyd_s};
  end

  // Chain controls are decoded from the next state and registered so the
  // pins never glitch; SHIFT_HI is never adjacent to LOAD, so the load and
  // the shift clock cannot be active together.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      bus.joyCk <= 1'b0;
      bus.joyLd <= 1'b1;
    end else begin
      bus.joyCk <= (state_nxt == SHIFT_HI);
      bus.joyLd <= (state_nxt != LOAD);
    end
  end

  // A frame is only published if it matches the one before it, which
  // filters single-frame noise on the cable.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      prev          <= '1;
      bus.joy1_o    <= '1;
      bus.joy2_o    <= '1;
      bus.joy_valid <= 1'b0;
    end else begin
      bus.joy_valid <= (state == DONE) && frame_match;
      if (state == DONE) begin
        prev <= frame;
        if (frame_match) begin
          bus.joy1_o <= frame_joy1(frame);
          bus.joy2_o <= frame_joy2(frame);
        end
      end
    end
  end

endmodule
